bcd_frame_counter: RTL and testbench

Frame-synchronised 4-digit BCD counter and column scanner that feeds the seven-segment decoder stage. It counts video frames, or steps on demand, into a packed BCD value that changes only at vsync to avoid tearing. From the current horizontal position it presents the digit for that screen column on a 4-bit `digit` bus. Sits between the hvsync generator and the seven-segment decoder / bitmap path.

---
 rtl/bcd_frame_counter_if.sv | 33 +++
 rtl/bcd_frame_counter.sv | 142 ++++++++++++++
 tb/tb_bcd_frame_counter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_frame_counter_if.sv
// bcd_frame_counter_if
//   Groups the video-side controls and the counter/scanner outputs of bcd_frame_counter.
//   master: the driver side (hvsync generator / control logic, or a testbench).
//   slave : the bcd_frame_counter side.
//   Signals:
//     vsync  - frame sync level, active-high
//     hpos   - current horizontal pixel position
//     run    - 1 = automatic frame counting
//     step   - one-cycle request for one extra increment at the next frame boundary
//     clear  - synchronous clear, highest priority
//     digit  - BCD digit for the current column, 4'hF = blank
//     value  - packed BCD {d3,d2,d1,d0}
//     carry  - one-cycle pulse on 9999 -> 0000
interface bcd_frame_counter_if;
   logic        vsync;
   logic [9:0]  hpos;
   logic        run;
   logic        step;
   logic        clear;
   logic [3:0]  digit;
   logic [15:0] value;
   logic        carry;

   modport master (
      output vsync, hpos, run, step, clear,
      input  digit, value, carry
   );

   modport slave (
      input  vsync, hpos, run, step, clear,
      output digit, value, carry
   );
endinterface

// File: rtl/bcd_frame_counter.sv
// bcd_frame_counter
//   Frame-synchronised 4-digit BCD counter with a column scanner for the seven-segment path.
//   The count advances only on the vsync rising edge (automatic prescaled ticks and/or
//   latched step requests), so the displayed number never changes mid-frame.
//   Ports:
//     clk     - pixel clock, rising-edge
//     reset_n - asynchronous active-low reset
//     bus     - bcd_frame_counter_if.slave (vsync, hpos, run, step, clear in;
//               digit, value, carry out)
//   Parameters:
//     FRAMES_PER_TICK - frames per automatic step, 1..255
//     FIRST_COL       - hpos[7:4] column showing the most-significant digit, 0..12
//   Build option:
//     LEADING_ZERO_BLANK_EN - when defined, leading zero digits (above the highest nonzero
//                             digit) are shown blank; d0 is always shown.
module bcd_frame_counter #(
   parameter int unsigned FRAMES_PER_TICK = 60,
   parameter int unsigned FIRST_COL       = 0
) (
   input logic                clk,
   input logic                reset_n,
   bcd_frame_counter_if.slave bus
);

   localparam logic [7:0] PreMax   = 8'(FRAMES_PER_TICK - 1);
   localparam logic [3:0] FirstCol = 4'(FIRST_COL);

   logic        vs_q;
   logic        armed_q;
   logic [7:0]  pre_q, pre_d;
   logic        step_pend_q, step_pend_d;
   logic [15:0] value_q, value_d;
   logic        carry_q, carry_d;
   logic [3:0]  digit_q, digit_d;

   logic        frame_tick;
   logic        auto_inc;
   logic        do_inc;
   logic        wrap;
   logic [15:0] value_inc;

   logic [3:0]  col;
   logic [3:0]  k;
   logic        in_window;
   logic [2:0]  lead_blank;

   // armed_q is low only in the first cycle after reset release, so a vsync that is already
   // high at release is absorbed into vs_q without producing a tick.
   assign frame_tick = bus.vsync & ~vs_q & armed_q;
   assign auto_inc   = frame_tick & bus.run & (pre_q == PreMax);
   assign do_inc     = frame_tick & (auto_inc | step_pend_q | bus.step);
   assign wrap       = (value_q == 16'h9999);

   // Ripple BCD increment: each 9 rolls to 0 and passes the carry upward.
   always_comb begin : bcd_inc
      logic c;
      value_inc = value_q;
      c         = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (value_q[4*i +: 4] >= 4'd9) begin
               value_inc[4*i +: 4] = 4'd0;
            end else begin
               value_inc[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
               c                   = 1'b0;
            end
         end
      end
   end

   always_comb begin : next_state
      pre_d       = pre_q;
      step_pend_d = step_pend_q | bus.step;
      value_d     = value_q;
      carry_d     = 1'b0;
      if (bus.clear) begin
         pre_d       = 8'd0;
         step_pend_d = 1'b0;
         value_d     = 16'h0000;
      end else if (frame_tick) begin
         // A step in the tick cycle is consumed here rather than left pending.
         step_pend_d = 1'b0;
         if (bus.run) begin
            pre_d = (pre_q == PreMax) ? 8'd0 : pre_q + 8'd1;
         end
         if (do_inc) begin
            value_d = value_inc;
            carry_d = wrap;
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   // lead_blank[2] -> d3, [1] -> d2, [0] -> d1 suppressed as leading zeros.
   assign lead_blank[2] = (value_q[15:12] == 4'd0);
   assign lead_blank[1] = lead_blank[2] & (value_q[11:8] == 4'd0);
   assign lead_blank[0] = lead_blank[1] & (value_q[7:4] == 4'd0);
`else
   assign lead_blank = 3'b000;
`endif

   always_comb begin : scanner
      col       = bus.hpos[7:4];
      k         = col - FirstCol;
      in_window = (bus.hpos[9:8] == 2'b00) && (col >= FirstCol) && (k <= 4'd3);
      digit_d   = 4'hF;
      if (in_window) begin
         unique case (k[1:0])
            2'd0: digit_d = lead_blank[2] ? 4'hF : value_q[15:12];
            2'd1: digit_d = lead_blank[1] ? 4'hF : value_q[11:8];
            2'd2: digit_d = lead_blank[0] ? 4'hF : value_q[7:4];
            2'd3: digit_d = value_q[3:0];
            default: digit_d = 4'hF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_q        <= 1'b0;
         armed_q     <= 1'b0;
         pre_q       <= 8'd0;
         step_pend_q <= 1'b0;
         value_q     <= 16'h0000;
         carry_q     <= 1'b0;
         digit_q     <= 4'hF;
      end else begin
         vs_q        <= bus.vsync;
         armed_q     <= 1'b1;
         pre_q       <= pre_d;
         step_pend_q <= step_pend_d;
         value_q     <= value_d;
         carry_q     <= carry_d;
         digit_q     <= digit_d;
      end
   end

   assign bus.value = value_q;
   assign bus.carry = carry_q;
   assign bus.digit = digit_q;

endmodule

// File: tb/tb_bcd_frame_counter.sv
module tb_bcd_frame_counter;

   localparam int unsigned Fpt      = 2;
   localparam int unsigned FirstCol = 2;

   logic clk = 1'b0;
   logic reset_n;

   bcd_frame_counter_if bus ();

   bcd_frame_counter #(
      .FRAMES_PER_TICK(Fpt),
      .FIRST_COL      (FirstCol)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: count as a plain integer, prescaler as a frame count modulo Fpt.
   int         m_count;
   int         m_frames;
   bit         m_pend;
   bit         m_vs;
   bit         m_armed;
   bit         m_carry;
   logic [3:0] m_digit;

   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
   endfunction

   function automatic logic [3:0] show(input int n, input logic [9:0] hpos);
      int col, k, pos, pw;
      col = int'(hpos[7:4]);
      k   = col - int'(FirstCol);
      if (hpos[9:8] != 2'b00 || k < 0 || k > 3) return 4'hF;
      pos = 3 - k;
      pw  = (pos == 3) ? 1000 : (pos == 2) ? 100 : (pos == 1) ? 10 : 1;
`ifdef LEADING_ZERO_BLANK_EN
      if (pos > 0 && n < pw) return 4'hF;
`endif
      return 4'((n / pw) % 10);
   endfunction

   task automatic model_reset();
      m_count  = 0;
      m_frames = 0;
      m_pend   = 1'b0;
      m_vs     = 1'b0;
      m_armed  = 1'b0;
      m_carry  = 1'b0;
      m_digit  = 4'hF;
   endtask

   // Advance one clock: update the model from the inputs seen at the edge, return at negedge.
   task automatic cycle();
      bit tick, auto_f;
      @(posedge clk);
      tick    = bus.vsync && !m_vs && m_armed;
      auto_f  = 1'b0;
      m_digit = show(m_count, bus.hpos);
      m_carry = 1'b0;
      if (bus.clear) begin
         m_count  = 0;
         m_frames = 0;
         m_pend   = 1'b0;
      end else if (tick) begin
         if (bus.run) begin
            m_frames = (m_frames + 1) % Fpt;
            auto_f   = (m_frames == 0);
         end
         if (auto_f || m_pend || bus.step) begin
            m_carry = (m_count == 9999);
            m_count = (m_count + 1) % 10000;
         end
         m_pend = 1'b0;
      end else if (bus.step) begin
         m_pend = 1'b1;
      end
      m_vs    = bus.vsync;
      m_armed = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      cycle();
      bus.clear = 1'b0;
   endtask

   // One stepped frame: step coincident with the vsync rise.
   task automatic step_frame();
      bus.vsync = 1'b1;
      bus.step  = 1'b1;
      cycle();
      bus.vsync = 1'b0;
      bus.step  = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      bus.vsync = 1'b0;
      bus.hpos  = 10'd0;
      bus.run   = 1'b0;
      bus.step  = 1'b0;
      bus.clear = 1'b0;
      reset_n   = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      bus.hpos = 10'd40;
      cycle();
      checks++;
      if (bus.value !== 16'h0000) begin
         failures++;
         $display("FAIL reset_value got=%h exp=0000", bus.value);
      end
      checks++;
      if (bus.carry !== 1'b0) begin
         failures++;
         $display("FAIL reset_carry got=%b exp=0", bus.carry);
      end
      checks++;
      if (bus.digit !== m_digit) begin
         failures++;
         $display("FAIL reset_digit got=%h exp=%h", bus.digit, m_digit);
      end
   endtask

   task automatic test_idle();
      bit bad_v, bad_c, bad_d;
      bad_v = 0; bad_c = 0; bad_d = 0;
      bus.run  = 1'b0;
      bus.step = 1'b0;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 8; c++) begin
            bus.vsync = (c >= 5);
            bus.hpos  = 10'($urandom_range(0, 799));
            cycle();
            if (bus.value !== 16'h0000) bad_v = 1;
            if (bus.carry !== 1'b0) bad_c = 1;
            if (bus.digit !== m_digit) bad_d = 1;
         end
      end
      checks++;
      if (bad_v) begin
         failures++;
         $display("FAIL idle_value got=%h exp=0000", bus.value);
      end
      checks++;
      if (bad_c) begin
         failures++;
         $display("FAIL idle_carry got=high exp=never high");
      end
      checks++;
      if (bad_d) begin
         failures++;
         $display("FAIL idle_digit got=%h exp=%h (last)", bus.digit, m_digit);
      end
   endtask

   task automatic test_auto();
      logic [15:0] prev;
      int          changes;
      bit          bad_time;
      bus.vsync = 1'b0;
      do_clear();
      bus.run  = 1'b1;
      changes  = 0;
      bad_time = 0;
      prev     = bus.value;
      for (int f = 0; f < 10; f++) begin
         for (int c = 0; c < 6; c++) begin
            bus.vsync = (c >= 3);
            bus.hpos  = 10'($urandom_range(0, 799));
            cycle();
            if (bus.value !== prev) begin
               changes++;
               if (c != 3) bad_time = 1;
            end
            prev = bus.value;
         end
      end
      checks++;
      if (bus.value !== 16'h0005) begin
         failures++;
         $display("FAIL auto_value got=%h exp=0005", bus.value);
      end
      checks++;
      if (changes != 5 || bad_time) begin
         failures++;
         $display("FAIL auto_timing got=%0d changes late=%0b exp=5 changes at rise+1",
                  changes, bad_time);
      end
      bus.run   = 1'b0;
      bus.vsync = 1'b0;
      cycle();
   endtask

   task automatic test_wrap();
      bit saw_carry;
      bus.run   = 1'b0;
      bus.vsync = 1'b0;
      do_clear();
      saw_carry = 0;
      for (int i = 0; i < 9999; i++) begin
         step_frame();
         if (bus.carry !== 1'b0) saw_carry = 1;
      end
      checks++;
      if (bus.value !== 16'h9999 || m_count != 9999) begin
         failures++;
         $display("FAIL wrap_preload got=%h exp=9999", bus.value);
      end
      checks++;
      if (saw_carry) begin
         failures++;
         $display("FAIL wrap_early_carry got=high exp=low before wrap");
      end
      bus.step = 1'b1;
      cycle();
      bus.step = 1'b0;
      cycle();
      checks++;
      if (bus.value !== 16'h9999) begin
         failures++;
         $display("FAIL wrap_step_pending got=%h exp=9999", bus.value);
      end
      bus.vsync = 1'b1;
      cycle();
      checks++;
      if (bus.value !== 16'h0000 || bus.carry !== 1'b1) begin
         failures++;
         $display("FAIL wrap_rollover got=%h/%b exp=0000/1", bus.value, bus.carry);
      end
      cycle();
      checks++;
      if (bus.carry !== 1'b0 || bus.value !== 16'h0000) begin
         failures++;
         $display("FAIL wrap_carry_width got=%h/%b exp=0000/0", bus.value, bus.carry);
      end
      bus.vsync = 1'b0;
      cycle();
   endtask

   task automatic test_collapse();
      bus.vsync = 1'b0;
      do_clear();
      bus.run   = 1'b1;
      bus.vsync = 1'b1;
      cycle();
      for (int c = 0; c < 7; c++) begin
         bus.vsync = 1'b0;
         bus.step  = (c % 2 == 1);
         cycle();
      end
      bus.step = 1'b0;
      checks++;
      if (bus.value !== 16'h0000) begin
         failures++;
         $display("FAIL collapse_before got=%h exp=0000", bus.value);
      end
      bus.vsync = 1'b1;
      bus.step  = 1'b1;
      cycle();
      bus.step = 1'b0;
      checks++;
      if (bus.value !== 16'h0001 || bus.value !== to_bcd(m_count)) begin
         failures++;
         $display("FAIL collapse_single got=%h exp=0001", bus.value);
      end
      bus.run   = 1'b0;
      bus.vsync = 1'b0;
      cycle();
      bus.vsync = 1'b1;
      cycle();
      checks++;
      if (bus.value !== 16'h0001) begin
         failures++;
         $display("FAIL collapse_no_leftover got=%h exp=0001", bus.value);
      end
      bus.vsync = 1'b0;
      cycle();
   endtask

   task automatic test_clear_tick();
      bus.run   = 1'b0;
      bus.vsync = 1'b0;
      do_clear();
      for (int i = 0; i < 99; i++) step_frame();
      checks++;
      if (bus.value !== 16'h0099) begin
         failures++;
         $display("FAIL clear_preload got=%h exp=0099", bus.value);
      end
      bus.run   = 1'b1;
      bus.vsync = 1'b1;
      bus.step  = 1'b1;
      bus.clear = 1'b1;
      cycle();
      bus.step  = 1'b0;
      bus.clear = 1'b0;
      checks++;
      if (bus.value !== 16'h0000 || bus.carry !== 1'b0) begin
         failures++;
         $display("FAIL clear_tick got=%h/%b exp=0000/0", bus.value, bus.carry);
      end
      // Prescaler restarted: first run frame after clear must not increment, second must.
      bus.vsync = 1'b0;
      cycle();
      bus.vsync = 1'b1;
      cycle();
      checks++;
      if (bus.value !== 16'h0000) begin
         failures++;
         $display("FAIL clear_pre_first got=%h exp=0000", bus.value);
      end
      bus.vsync = 1'b0;
      cycle();
      bus.vsync = 1'b1;
      cycle();
      checks++;
      if (bus.value !== 16'h0001) begin
         failures++;
         $display("FAIL clear_pre_second got=%h exp=0001", bus.value);
      end
      bus.run   = 1'b0;
      bus.vsync = 1'b0;
      cycle();
   endtask

   task automatic test_scan();
      logic [9:0] h;
      logic [3:0] want;
      int         bad_model, bad_table;
      bus.run   = 1'b0;
      bus.vsync = 1'b0;
      do_clear();
      for (int i = 0; i < 42; i++) step_frame();
      checks++;
      if (bus.value !== 16'h0042) begin
         failures++;
         $display("FAIL scan_preload got=%h exp=0042", bus.value);
      end
      bad_model = 0;
      bad_table = 0;
      for (int x = 0; x < 800; x++) begin
         h        = 10'(x);
         bus.hpos = h;
         cycle();
         want = 4'hF;
         if (h[9:8] == 2'b00) begin
            case (h[7:4])
`ifdef LEADING_ZERO_BLANK_EN
               4'd2: want = 4'hF;
               4'd3: want = 4'hF;
`else
               4'd2: want = 4'd0;
               4'd3: want = 4'd0;
`endif
               4'd4: want = 4'd4;
               4'd5: want = 4'd2;
               default: want = 4'hF;
            endcase
         end
         checks++;
         if (bus.digit !== want) begin
            failures++;
            bad_table++;
            if (bad_table <= 4)
               $display("FAIL scan_table hpos=%0d got=%h exp=%h", x, bus.digit, want);
         end
         checks++;
         if (bus.digit !== m_digit) begin
            failures++;
            bad_model++;
            if (bad_model <= 4)
               $display("FAIL scan_model hpos=%0d got=%h exp=%h", x, bus.digit, m_digit);
         end
      end
   endtask

   task automatic test_async_reset();
      bus.vsync = 1'b1;
      bus.hpos  = 10'd64;
      cycle();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (bus.value !== 16'h0000 || bus.digit !== 4'hF || bus.carry !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got=%h/%h/%b exp=0000/f/0", bus.value, bus.digit,
                  bus.carry);
      end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) cycle();
      checks++;
      if (bus.value !== 16'h0000) begin
         failures++;
         $display("FAIL release_high_vsync got=%h exp=0000", bus.value);
      end
      bus.vsync = 1'b0;
      bus.step  = 1'b1;
      cycle();
      bus.step  = 1'b0;
      bus.vsync = 1'b1;
      cycle();
      checks++;
      if (bus.value !== 16'h0001) begin
         failures++;
         $display("FAIL release_new_edge got=%h exp=0001", bus.value);
      end
   endtask

   task automatic test_random();
      int phase_left;
      bit hi;
      int bad;
      bad        = 0;
      hi         = 1'b0;
      phase_left = 2;
      for (int i = 0; i < 3000; i++) begin
         if (phase_left == 0) begin
            hi         = !hi;
            phase_left = hi ? $urandom_range(1, 4) : $urandom_range(1, 6);
         end
         phase_left--;
         bus.vsync = hi;
         bus.run   = ($urandom_range(0, 3) != 0);
         bus.step  = ($urandom_range(0, 7) == 0);
         bus.clear = ($urandom_range(0, 99) == 0);
         bus.hpos  = 10'($urandom_range(0, 1023));
         cycle();
         checks++;
         if (bus.value !== to_bcd(m_count) || bus.carry !== m_carry ||
             bus.digit !== m_digit) begin
            failures++;
            bad++;
            if (bad <= 5)
               $display("FAIL random cyc=%0d got=%h/%b/%h exp=%h/%b/%h", i, bus.value,
                        bus.carry, bus.digit, to_bcd(m_count), m_carry, m_digit);
         end
      end
      bus.clear = 1'b0;
      bus.step  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_auto();
      test_collapse();
      test_clear_tick();
      test_scan();
      test_random();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
